// File: rtl/draw_player_ctl.sv
// Player mallet controller: steps the mallet one pixel per movement tick toward
// the clamped mouse position, and parks it at home for a fixed freeze after each goal.
module draw_player_ctl #(
  parameter int PLAYERS_RADIUS = 20,
  parameter int STEP_DIV       = 65000,
  parameter int FREEZE_TICKS   = 500
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic [11:0] xpos_mouse,
  input  logic [11:0] ypos_mouse,
  input  logic [3:0]  player_1_score,
  input  logic [3:0]  player_2_score,
  output logic [11:0] xpos_player_1,
  output logic [11:0] ypos_player_1,
  output logic        freeze,
  output logic        at_target
);

  localparam logic [11:0] X_MIN    = 12'(44 + PLAYERS_RADIUS);
  localparam logic [11:0] X_MAX    = 12'(512 - PLAYERS_RADIUS);
  localparam logic [11:0] Y_MIN    = 12'(44 + PLAYERS_RADIUS);
  localparam logic [11:0] Y_MAX    = 12'(725 - PLAYERS_RADIUS);
  localparam logic [11:0] HOME_X   = 12'd150;
  localparam logic [11:0] HOME_Y   = 12'd362;
  localparam logic [19:0] CNT_LAST = 20'(STEP_DIV - 1);
  localparam logic [11:0] FRZ_LOAD = 12'(FREEZE_TICKS - 1);

  typedef enum logic {TRACK, FREEZE} state_t;

  function automatic logic [11:0] clamp(input logic [11:0] v,
                                        input logic [11:0] lo,
                                        input logic [11:0] hi);
    logic [11:0] r;
    r = (v < lo) ? lo : v;
    r = (r > hi) ? hi : r;
    return r;
  endfunction

  function automatic logic [11:0] step_toward(input logic [11:0] pos,
                                              input logic [11:0] tgt);
    logic [11:0] r;
    r = pos;
    if (pos < tgt)      r = pos + 12'd1;
    else if (pos > tgt) r = pos - 12'd1;
    return r;
  endfunction

  state_t      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [11:0] x_q, x_d;
  logic [11:0] y_q, y_d;
  logic [11:0] fcnt_q, fcnt_d;
  logic [3:0]  prev_p1_q, prev_p2_q;
  logic        freeze_q, freeze_d;
  logic        at_target_q, at_target_d;
  logic        tick;
  logic        goal;
  logic [11:0] tx, ty;

  always_comb begin
    tick  = (cnt_q == CNT_LAST);
    cnt_d = tick ? 20'd0 : cnt_q + 20'd1;
    goal  = (player_1_score != prev_p1_q) || (player_2_score != prev_p2_q);
    tx    = clamp(xpos_mouse, X_MIN, X_MAX);
    ty    = clamp(ypos_mouse, Y_MIN, Y_MAX);

    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    fcnt_d  = fcnt_q;

    // A goal overrides any tick in the same cycle and always reloads the full freeze.
    if (goal) begin
      state_d = FREEZE;
      x_d     = HOME_X;
      y_d     = HOME_Y;
      fcnt_d  = FRZ_LOAD;
    end else begin
      unique case (state_q)
        TRACK: begin
          if (tick) begin
            x_d = step_toward(x_q, tx);
            y_d = step_toward(y_q, ty);
          end
        end
        FREEZE: begin
          if (tick) begin
            if (fcnt_q == 12'd0) state_d = TRACK;
            else                 fcnt_d  = fcnt_q - 12'd1;
          end
        end
        default: state_d = TRACK;
      endcase
    end

    freeze_d    = (state_d == FREEZE);
    at_target_d = (state_d == TRACK) && (x_d == tx) && (y_d == ty);
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q     <= TRACK;
      cnt_q       <= 20'd0;
      x_q         <= HOME_X;
      y_q         <= HOME_Y;
      fcnt_q      <= 12'd0;
      prev_p1_q   <= player_1_score;
      prev_p2_q   <= player_2_score;
      freeze_q    <= 1'b0;
      at_target_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      fcnt_q      <= fcnt_d;
      prev_p1_q   <= player_1_score;
      prev_p2_q   <= player_2_score;
      freeze_q    <= freeze_d;
      at_target_q <= at_target_d;
    end
  end

  assign xpos_player_1 = x_q;
  assign ypos_player_1 = y_q;
  assign freeze        = freeze_q;
  assign at_target     = at_target_q;

endmodule
